// File: rtl/mem_access_unit.sv
// Load/store access stage: classifies ops, drives a non-blocking dcache port and
// completes ops in order through a small metadata FIFO with registered writeback.
module mem_access_unit #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned TAG_W           = 6,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                llbit_clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [3:0]          in_op_i,
    input  logic [ADDR_W-1:0]   in_addr_i,
    input  logic [DATA_W-1:0]   in_wdata_i,
    input  logic [TAG_W-1:0]    in_tag_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic                req_we_o,
    output logic [ADDR_W-1:0]   req_addr_o,
    output logic [DATA_W/8-1:0] req_wstrb_o,
    output logic [DATA_W-1:0]   req_wdata_o,
    input  logic                rsp_valid_i,
    input  logic [DATA_W-1:0]   rsp_rdata_i,
    output logic                out_valid_o,
    output logic [TAG_W-1:0]    out_tag_o,
    output logic                out_wen_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [1:0]          out_excp_o,
    output logic [ADDR_W-1:0]   out_bad_addr_o
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LaneW = $clog2(NB);
    localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpLdB  = 4'd1;
    localparam logic [3:0] OpLdBu = 4'd2;
    localparam logic [3:0] OpLdH  = 4'd3;
    localparam logic [3:0] OpLdHu = 4'd4;
    localparam logic [3:0] OpLdW  = 4'd5;
    localparam logic [3:0] OpStB  = 4'd6;
    localparam logic [3:0] OpStH  = 4'd7;
    localparam logic [3:0] OpStW  = 4'd8;
    localparam logic [3:0] OpLlW  = 4'd9;
    localparam logic [3:0] OpScW  = 4'd10;
    localparam logic [3:0] OpLdD  = 4'd11;
    localparam logic [3:0] OpStD  = 4'd12;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [3:0]        op;
        logic [LaneW-1:0]  lane;
        logic              is_local;
        logic [1:0]        excp;
        logic [ADDR_W-1:0] bad_addr;
        logic              sc_ok;
    } entry_t;

    entry_t            fifo_q [MAX_OUTSTANDING];
    entry_t            head, push_entry;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d, mem_cnt_q, mem_cnt_d, drop_q, drop_d;
    logic              llbit_q, llbit_d;

    logic              is_nop, is_st, is_ll, is_sc, ine, ale;
    logic [1:0]        sz;
    logic              llbit_eff, sc_fail, op_local, fifo_full, can_take, push;
    logic              head_valid, pop, head_mem_pop, rsp_drop;
    logic [DATA_W-1:0] sh;

    logic              out_valid_q, out_wen_q, out_wen_d;
    logic [TAG_W-1:0]  out_tag_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_excp_q;
    logic [ADDR_W-1:0] out_bad_addr_q;

    // Input decode: access size code (0 B, 1 H, 2 W, 3 D) and fault classification.
    always_comb begin
        is_nop = 1'b0;
        is_st  = 1'b0;
        is_ll  = 1'b0;
        is_sc  = 1'b0;
        ine    = 1'b0;
        ale    = 1'b0;
        sz     = 2'd0;
        case (in_op_i)
            OpNop:         is_nop = 1'b1;
            OpLdB, OpLdBu: sz = 2'd0;
            OpLdH, OpLdHu: begin sz = 2'd1; ale = in_addr_i[0]; end
            OpLdW:         begin sz = 2'd2; ale = |in_addr_i[1:0]; end
            OpStB:         begin sz = 2'd0; is_st = 1'b1; end
            OpStH:         begin sz = 2'd1; is_st = 1'b1; ale = in_addr_i[0]; end
            OpStW:         begin sz = 2'd2; is_st = 1'b1; ale = |in_addr_i[1:0]; end
            OpLlW:         begin sz = 2'd2; is_ll = 1'b1; ale = |in_addr_i[1:0]; end
            OpScW:         begin sz = 2'd2; is_sc = 1'b1; is_st = 1'b1; ale = |in_addr_i[1:0]; end
            OpLdD, OpStD: begin
                if (DATA_W == 64) begin
                    sz    = 2'd3;
                    is_st = (in_op_i == OpStD);
                    ale   = |in_addr_i[2:0];
                end else begin
                    ine = 1'b1;
                end
            end
            default:       ine = 1'b1;
        endcase
    end

    // A clear arriving with the SC wins; an LL accepted with a clear still sets LLbit.
    assign llbit_eff  = llbit_q && !llbit_clear_i;
    assign sc_fail    = is_sc && !ine && !ale && !llbit_eff;
    assign op_local   = is_nop || ine || ale || sc_fail;
    assign fifo_full  = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign can_take   = !rst && !flush_i && (drop_q == '0) && !fifo_full;
    assign in_ready_o = can_take && (op_local || req_ready_i);
    assign push       = in_valid_i && in_ready_o;

    assign req_valid_o = in_valid_i && !op_local && can_take;
    assign req_we_o    = is_st;
    assign req_addr_o  = in_addr_i;

    always_comb begin
        case (sz)
            2'd0: begin
                req_wstrb_o = NB'(8'h01) << in_addr_i[LaneW-1:0];
                req_wdata_o = {NB{in_wdata_i[7:0]}};
            end
            2'd1: begin
                req_wstrb_o = NB'(8'h03) << in_addr_i[LaneW-1:0];
                req_wdata_o = {(NB/2){in_wdata_i[15:0]}};
            end
            2'd2: begin
                req_wstrb_o = NB'(8'h0F) << in_addr_i[LaneW-1:0];
                req_wdata_o = {(NB/4){in_wdata_i[31:0]}};
            end
            default: begin
                req_wstrb_o = NB'(8'hFF);
                req_wdata_o = in_wdata_i;
            end
        endcase
    end

    always_comb begin
        push_entry.tag      = in_tag_i;
        push_entry.op       = in_op_i;
        push_entry.lane     = in_addr_i[LaneW-1:0];
        push_entry.is_local = op_local;
        push_entry.excp     = {ine, ale};
        push_entry.bad_addr = in_addr_i;
        push_entry.sc_ok    = is_sc && llbit_eff;
    end

    // Responses first retire flushed requests; only then do they complete the head.
    assign head         = fifo_q[rd_ptr_q];
    assign head_valid   = (cnt_q != '0);
    assign rsp_drop     = rsp_valid_i && (drop_q != '0);
    assign pop          = head_valid && (head.is_local || (rsp_valid_i && drop_q == '0));
    assign head_mem_pop = pop && !head.is_local;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PtrW'(push);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        cnt_d     = cnt_q + CntW'(push) - CntW'(pop);
        mem_cnt_d = mem_cnt_q + CntW'(push && !op_local) - CntW'(head_mem_pop);
        drop_d    = drop_q - CntW'(rsp_drop);
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            mem_cnt_d = '0;
            drop_d    = drop_d + mem_cnt_q - CntW'(head_mem_pop);
        end
    end

    always_comb begin
        llbit_d = llbit_q;
        if (push && is_ll && !ine && !ale) begin
            llbit_d = 1'b1;
        end else if ((push && is_sc && !ine && !ale) || llbit_clear_i) begin
            llbit_d = 1'b0;
        end
    end

    assign sh = rsp_rdata_i >> {head.lane, 3'b000};

    always_comb begin
        out_wen_d  = 1'b0;
        out_data_d = '0;
        if (head.excp == 2'b00) begin
            case (head.op)
                OpLdB:        begin out_wen_d = 1'b1; out_data_d = DATA_W'($signed(sh[7:0])); end
                OpLdBu:       begin out_wen_d = 1'b1; out_data_d = DATA_W'(sh[7:0]); end
                OpLdH:        begin out_wen_d = 1'b1; out_data_d = DATA_W'($signed(sh[15:0])); end
                OpLdHu:       begin out_wen_d = 1'b1; out_data_d = DATA_W'(sh[15:0]); end
                OpLdW, OpLlW: begin out_wen_d = 1'b1; out_data_d = DATA_W'($signed(sh[31:0])); end
                OpLdD:        begin out_wen_d = 1'b1; out_data_d = sh; end
                OpScW:        begin out_wen_d = 1'b1; out_data_d = DATA_W'(head.sc_ok); end
                default:      out_wen_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            mem_cnt_q      <= '0;
            drop_q         <= '0;
            llbit_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_tag_q      <= '0;
            out_wen_q      <= 1'b0;
            out_data_q     <= '0;
            out_excp_q     <= 2'b00;
            out_bad_addr_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            mem_cnt_q      <= mem_cnt_d;
            drop_q         <= drop_d;
            llbit_q        <= llbit_d;
            out_valid_q    <= pop && !flush_i;
            out_tag_q      <= (pop && !flush_i) ? head.tag : '0;
            out_wen_q      <= (pop && !flush_i) ? out_wen_d : 1'b0;
            out_data_q     <= (pop && !flush_i) ? out_data_d : '0;
            out_excp_q     <= (pop && !flush_i) ? head.excp : 2'b00;
            out_bad_addr_q <= (pop && !flush_i && head.excp != 2'b00) ? head.bad_addr : '0;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_tag_o      = out_tag_q;
    assign out_wen_o      = out_wen_q;
    assign out_data_o     = out_data_q;
    assign out_excp_o     = out_excp_q;
    assign out_bad_addr_o = out_bad_addr_q;

    // A response must either retire a flushed request or match a mem op at the head.
    assert property (@(posedge clk) disable iff (rst)
        rsp_valid_i |-> (drop_q != '0 || (head_valid && !head.is_local)))
        else $error("mem_access_unit: rsp_valid with no outstanding request");

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scoreboarded completions on a 32-bit instance plus
// a short directed doubleword check on a 64-bit instance.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush, llbit_clear, in_valid, in_ready, req_valid, req_ready, req_we;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_wdata, req_addr, req_wdata, rsp_rdata, out_data, out_bad_addr;
    logic [5:0]  in_tag, out_tag;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, out_valid, out_wen;
    logic [1:0]  out_excp;

    logic        in_valid64, in_ready64, req_valid64, req_we64, rsp_valid64;
    logic        out_valid64, out_wen64;
    logic [3:0]  in_op64;
    logic [31:0] in_addr64, req_addr64, out_bad_addr64;
    logic [63:0] in_wdata64, req_wdata64, rsp_rdata64, out_data64;
    logic [5:0]  in_tag64, out_tag64;
    logic [7:0]  req_wstrb64;
    logic [1:0]  out_excp64;

    typedef struct packed {
        logic [5:0]  tag;
        logic        wen;
        logic [31:0] data;
        logic [1:0]  excp;
        logic [31:0] bad;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    logic        rsp_en;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TAG_W(6), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .llbit_clear_i(llbit_clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_addr_i(in_addr),
        .in_wdata_i(in_wdata), .in_tag_i(in_tag), .req_valid_o(req_valid),
        .req_ready_i(req_ready), .req_we_o(req_we), .req_addr_o(req_addr),
        .req_wstrb_o(req_wstrb), .req_wdata_o(req_wdata), .rsp_valid_i(rsp_valid),
        .rsp_rdata_i(rsp_rdata), .out_valid_o(out_valid), .out_tag_o(out_tag),
        .out_wen_o(out_wen), .out_data_o(out_data), .out_excp_o(out_excp),
        .out_bad_addr_o(out_bad_addr)
    );

    mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TAG_W(6), .MAX_OUTSTANDING(4)) dut64 (
        .clk(clk), .rst(rst), .flush_i(1'b0), .llbit_clear_i(1'b0),
        .in_valid_i(in_valid64), .in_ready_o(in_ready64), .in_op_i(in_op64),
        .in_addr_i(in_addr64), .in_wdata_i(in_wdata64), .in_tag_i(in_tag64),
        .req_valid_o(req_valid64), .req_ready_i(1'b1), .req_we_o(req_we64),
        .req_addr_o(req_addr64), .req_wstrb_o(req_wstrb64), .req_wdata_o(req_wdata64),
        .rsp_valid_i(rsp_valid64), .rsp_rdata_i(rsp_rdata64), .out_valid_o(out_valid64),
        .out_tag_o(out_tag64), .out_wen_o(out_wen64), .out_data_o(out_data64),
        .out_excp_o(out_excp64), .out_bad_addr_o(out_bad_addr64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Drive one op until accepted; check the request side and queue the expected completion.
    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [5:0] tag, input logic [31:0] rdata, input logic xreq,
                        input logic xwe, input logic [3:0] xstrb, input logic [31:0] xwd,
                        input logic xwen, input logic [31:0] xdata, input logic [1:0] xexcp);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_tag   = tag;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("send_ready", in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        check_eq("req_valid", req_valid, xreq);
        if (xreq) begin
            check_eq("req_we", req_we, xwe);
            check_eq("req_wstrb", req_wstrb, xstrb);
            check_eq("req_wdata", req_wdata, xwd);
            check_eq("req_addr", req_addr, addr);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (xreq) pend_q.push_back(rdata);
        e.tag  = tag;
        e.wen  = xwen;
        e.data = xdata;
        e.excp = xexcp;
        e.bad  = (xexcp != 2'b00) ? addr : 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Memory model: answers queued requests in order, one per cycle, when enabled.
    initial begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_en && pend_q.size() != 0) begin
                rsp_valid = 1'b1;
                rsp_rdata = pend_q.pop_front();
            end else begin
                rsp_valid = 1'b0;
                rsp_rdata = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out_valid", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("out_tag", out_tag, e.tag);
                check_eq("out_wen", out_wen, e.wen);
                check_eq("out_data", out_data, e.data);
                check_eq("out_excp", out_excp, e.excp);
                check_eq("out_bad_addr", out_bad_addr, e.bad);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; llbit_clear = 1'b0; req_ready = 1'b1; rsp_en = 1'b1;
        in_valid = 1'b1; in_op = 4'd0; in_addr = '0; in_wdata = '0; in_tag = '0;
        in_valid64 = 1'b0; in_op64 = '0; in_addr64 = '0; in_wdata64 = '0; in_tag64 = '0;
        rsp_valid64 = 1'b0; rsp_rdata64 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_req_valid", req_valid, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_out_valid", out_valid, 1'b0);

        // NOP latency: nothing in the cycle after acceptance, completion one cycle later.
        send(4'd0, 32'h0, 32'h0, 6'd1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b00);
        check_eq("nop_t1_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("nop_t2_out_valid", out_valid, 1'b1);
        drain();

        // Loads and stores of each size and lane.
        send(4'd1, 32'h1003, 32'h0, 6'd2, 32'h80112233, 1'b1, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80, 2'b00);
        send(4'd2, 32'h1001, 32'h0, 6'd3, 32'h80112233, 1'b1, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h00000022, 2'b00);
        send(4'd4, 32'h1002, 32'h0, 6'd4, 32'h80112233, 1'b1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'h00008011, 2'b00);
        send(4'd3, 32'h1000, 32'h0, 6'd5, 32'h0000F00D, 1'b1, 1'b0, 4'b0011, 32'h0, 1'b1, 32'hFFFFF00D, 2'b00);
        send(4'd7, 32'h2002, 32'hABCD, 6'd6, 32'h0, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0, 2'b00);
        send(4'd6, 32'h2001, 32'h5A, 6'd7, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0, 2'b00);
        send(4'd8, 32'h2004, 32'hDEADBEEF, 6'd8, 32'h0, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0, 2'b00);
        // Misaligned and illegal ops never reach the cache.
        send(4'd5, 32'h1006, 32'h0, 6'd9, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b01);
        send(4'd3, 32'h1001, 32'h0, 6'd10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b01);
        send(4'd11, 32'h1008, 32'h0, 6'd11, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b10);
        send(4'd14, 32'h100C, 32'h0, 6'd12, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b10);
        drain();

        // LL/SC pairing.
        send(4'd9, 32'h3000, 32'h0, 6'd13, 32'h12345678, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h12345678, 2'b00);
        send(4'd10, 32'h3000, 32'h55, 6'd14, 32'h0, 1'b1, 1'b1, 4'b1111, 32'h55, 1'b1, 32'h1, 2'b00);
        send(4'd10, 32'h3000, 32'h66, 6'd15, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 2'b00);
        llbit_clear = 1'b1;
        send(4'd9, 32'h3000, 32'h0, 6'd16, 32'hA5A5A5A5, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hA5A5A5A5, 2'b00);
        llbit_clear = 1'b0;
        send(4'd10, 32'h3000, 32'h77, 6'd17, 32'h0, 1'b1, 1'b1, 4'b1111, 32'h77, 1'b1, 32'h1, 2'b00);
        send(4'd9, 32'h3000, 32'h0, 6'd18, 32'h00000001, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h1, 2'b00);
        llbit_clear = 1'b1;
        @(posedge clk);
        #1;
        llbit_clear = 1'b0;
        send(4'd10, 32'h3000, 32'h88, 6'd19, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 2'b00);
        drain();

        // Fill the FIFO with responses held off, then release them.
        rsp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd5, 32'h4000 + 32'(i * 4), 32'h0, 6'(20 + i), 32'h11110000 + 32'(i), 1'b1, 1'b0,
                 4'b1111, 32'h0, 1'b1, 32'h11110000 + 32'(i), 2'b00);
        end
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h4010; in_tag = 6'd30;
        #1;
        check_eq("full_in_ready", in_ready, 1'b0);
        check_eq("full_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        rsp_en = 1'b1;
        drain();

        // Flush with two loads in flight: their responses are swallowed.
        rsp_en = 1'b0;
        send(4'd5, 32'h5000, 32'h0, 6'd31, 32'hBAD0BAD0, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0, 2'b00);
        send(4'd5, 32'h5004, 32'h0, 6'd32, 32'hBAD1BAD1, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0, 2'b00);
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready0", in_ready, 1'b0);
        rsp_en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("flush_in_ready1", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_eq("flush_in_ready2", in_ready, 1'b1);
        send(4'd5, 32'h5008, 32'h0, 6'd33, 32'hCAFEF00D, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D, 2'b00);
        drain();

        // Doubleword load on the 64-bit instance.
        in_valid64 = 1'b1; in_op64 = 4'd11; in_addr64 = 32'h1008; in_tag64 = 6'd7;
        #1;
        check_eq("d64_in_ready", in_ready64, 1'b1);
        check_eq("d64_req_valid", req_valid64, 1'b1);
        check_eq("d64_req_wstrb", req_wstrb64, 8'hFF);
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        rsp_valid64 = 1'b1;
        rsp_rdata64 = 64'h0123456789ABCDEF;
        @(posedge clk);
        #1;
        rsp_valid64 = 1'b0;
        check_eq("d64_out_valid", out_valid64, 1'b1);
        check_eq("d64_out_data", out_data64, 64'h0123456789ABCDEF);
        check_eq("d64_out_wen", out_wen64, 1'b1);
        check_eq("d64_out_tag", out_tag64, 6'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
